// File: rtl/triroc_sc_pkg.sv
// Shared definitions for the TRIROC slow-control sequencer.
package triroc_sc_pkg;

    localparam int SC_WIDTH    = 16;
    localparam int SC_LOAD_GAP = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP1,
        ST_LDSC,
        ST_GAP2,
        ST_LDSCD,
        ST_DONE
    } sc_state_t;

endpackage

// File: rtl/triroc_sc_gap_timer.sv
// Down-counter timing the idle gaps that precede each latch strobe.
module triroc_sc_gap_timer (
    input  logic       ck_sr,
    input  logic       rstb_sr,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       expired
);

    logic [3:0] count;

    // Load on gap entry, then count down and rest at zero.
    always_ff @(posedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Zero means the current gap cycle is the last one.
    assign expired = (count == 4'd0);

endmodule

// File: rtl/triroc_sc_sequencer.sv
// Shifts a configuration word into the TRIROC slow-control chain, captures
// the previous chain contents, then issues the DAC and digital latch strobes.
module triroc_sc_sequencer
    import triroc_sc_pkg::*;
#(
    parameter int WIDTH    = SC_WIDTH,
    parameter int LOAD_GAP = SC_LOAD_GAP
) (
    input  logic             ck_sr,
    input  logic             rstb_sr,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_word,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] readback,
    output logic             sr_in,
    output logic             select,
    output logic             load_sc,
    output logic             load_scd,
    input  logic             sr_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [3:0] GAP_LOAD = (LOAD_GAP > 0) ? 4'(LOAD_GAP - 1) : 4'd0;
    // A zero gap routes straight past the gap states.
    localparam sc_state_t AFTER_SHIFT = (LOAD_GAP > 0) ? ST_GAP1 : ST_LDSC;
    localparam sc_state_t AFTER_LDSC  = (LOAD_GAP > 0) ? ST_GAP2 : ST_LDSCD;

    sc_state_t        state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [WIDTH-1:0] shadow, shadow_next;
    logic [WIDTH-1:0] readback_next;
    logic             gap_load;
    logic             gap_expired;

    triroc_sc_gap_timer u_gap_timer (
        .ck_sr      (ck_sr),
        .rstb_sr    (rstb_sr),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .expired    (gap_expired)
    );

    assign select = 1'b1;

    // Next-state, bit counter, shadow shift and readback capture.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shadow_next   = shadow;
        readback_next = readback;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SHIFT;
                    bit_cnt_next = '0;
                    shadow_next  = cfg_word;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (bit_cnt == CNT_W'(i)) readback_next[i] = sr_out;
                end
                shadow_next = shadow >> 1;
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    state_next   = AFTER_SHIFT;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            ST_GAP1:  if (gap_expired) state_next = ST_LDSC;
            ST_LDSC:  state_next = AFTER_LDSC;
            ST_GAP2:  if (gap_expired) state_next = ST_LDSCD;
            ST_LDSCD: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        gap_load = ((state == ST_SHIFT) && (state_next == ST_GAP1)) ||
                   ((state == ST_LDSC)  && (state_next == ST_GAP2));
    end

    // State register; outputs are registered from the next state so they align with it.
    always_ff @(posedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shadow   <= '0;
            // NOTE: readback is a plain register bank, not a memory, so it can and must clear on reset.
            readback <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sr_in    <= 1'b0;
            load_sc  <= 1'b1;
            load_scd <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values from its neighbours.
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            shadow   <= shadow_next;
            readback <= readback_next;
            busy     <= (state_next != ST_IDLE);
            done     <= (state_next == ST_DONE);
            sr_in    <= (state_next == ST_SHIFT) ? shadow_next[0] : 1'b0;
            load_sc  <= (state_next != ST_LDSC);
            load_scd <= (state_next != ST_LDSCD);
        end
    end

endmodule

// File: tb/tb_triroc_sc_sequencer.sv
// Bench for the slow-control sequencer: a 16-bit/gap-1 instance and a
// 1-bit/gap-0 instance, each with an external chain model on sr_out.
module tb_triroc_sc_sequencer;

    localparam int WA = 16;
    localparam int GA = 1;
    localparam int WB = 1;
    localparam int GB = 0;

    typedef struct packed {
        logic busy;
        logic done;
        logic sr_in;
        logic select;
        logic load_sc;
        logic load_scd;
    } obs_t;

    localparam obs_t IDLE_OBS = 6'b000111;

    typedef struct {
        logic [15:0] cfg;
        logic [15:0] cfg_late;
        logic [15:0] exp_rb;
    } vec_t;

    logic ck_sr = 1'b0;
    logic rstb_sr;

    logic        a_start, a_busy, a_done, a_sr_in, a_select, a_load_sc, a_load_scd, a_sr_out;
    logic [15:0] a_cfg, a_readback, chain_a;
    logic        b_start, b_busy, b_done, b_sr_in, b_select, b_load_sc, b_load_scd, b_sr_out;
    logic [0:0]  b_cfg, b_readback, chain_b;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   shift_a = 0;
    int   shift_b = 0;
    vec_t vecs[4];
    logic [15:0] snapshot;

    always #5 ck_sr = ~ck_sr;

    assign a_sr_out = chain_a[0];
    assign b_sr_out = chain_b[0];

    triroc_sc_sequencer #(.WIDTH(WA), .LOAD_GAP(GA)) u_dut_a (
        .ck_sr(ck_sr), .rstb_sr(rstb_sr), .start(a_start), .cfg_word(a_cfg),
        .busy(a_busy), .done(a_done), .readback(a_readback), .sr_in(a_sr_in),
        .select(a_select), .load_sc(a_load_sc), .load_scd(a_load_scd), .sr_out(a_sr_out)
    );

    triroc_sc_sequencer #(.WIDTH(WB), .LOAD_GAP(GB)) u_dut_b (
        .ck_sr(ck_sr), .rstb_sr(rstb_sr), .start(b_start), .cfg_word(b_cfg),
        .busy(b_busy), .done(b_done), .readback(b_readback), .sr_in(b_sr_in),
        .select(b_select), .load_sc(b_load_sc), .load_scd(b_load_scd), .sr_out(b_sr_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Expected outputs in cycle k after start acceptance (k=0 is the first SHIFT cycle).
    function automatic obs_t expect_at(input int w, input int g, input int k, input logic bit_k);
        obs_t o;
        o = IDLE_OBS;
        o.busy = 1'b1;
        if (k < w)                o.sr_in    = bit_k;
        else if (k == w + g)      o.load_sc  = 1'b0;
        else if (k == w + 2*g + 1) o.load_scd = 1'b0;
        else if (k == w + 2*g + 2) o.done     = 1'b1;
        return o;
    endfunction

    // One clock: chain models shift on the edge, then both DUTs are compared.
    task automatic tick();
        logic sa, sb;
        obs_t ea, eb, oa, ob;
        @(negedge ck_sr);
        sa = a_sr_in;
        sb = b_sr_in;
        @(posedge ck_sr);
        #1;
        if (shift_a > 0) begin
            chain_a = {sa, chain_a[15:1]};
            shift_a--;
        end
        if (shift_b > 0) begin
            chain_b = sb;
            shift_b--;
        end
        ea = (q_a.size() > 0) ? q_a.pop_front() : IDLE_OBS;
        eb = (q_b.size() > 0) ? q_b.pop_front() : IDLE_OBS;
        oa = {a_busy, a_done, a_sr_in, a_select, a_load_sc, a_load_scd};
        ob = {b_busy, b_done, b_sr_in, b_select, b_load_sc, b_load_scd};
        check($sformatf("a_outputs@%0t", $time), 32'(oa), 32'(ea));
        check($sformatf("b_outputs@%0t", $time), 32'(ob), 32'(eb));
    endtask

    // Full sequence on instance A; cfg_late is driven from the cycle after T0.
    task automatic run_a(input logic [15:0] cfg, input logic [15:0] cfg_late,
                         input logic [15:0] exp_rb, input bit hold_start, input string tag);
        int busy_cycles;
        busy_cycles = 0;
        for (int k = 0; k <= WA + 2*GA + 2; k++) q_a.push_back(expect_at(WA, GA, k, cfg[k]));
        a_cfg   = cfg;
        a_start = 1'b1;
        tick();
        busy_cycles += int'(a_busy);
        if (!hold_start) a_start = 1'b0;
        a_cfg   = cfg_late;
        shift_a = WA;
        for (int i = 1; i < WA + 2*GA + 4; i++) begin
            tick();
            busy_cycles += int'(a_busy);
            if (hold_start && i == WA + 2*GA + 3) a_start = 1'b0;
        end
        check({tag, "_readback"}, 32'(a_readback), 32'(exp_rb));
        check({tag, "_chain"}, 32'(chain_a), 32'(cfg));
        // busy covers the SHIFT cycles through DONE: WIDTH + 2*LOAD_GAP + 3.
        if (hold_start) check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WA + 2*GA + 3));
    endtask

    initial begin
        vecs[0] = '{cfg: 16'hDAF1, cfg_late: 16'hDAF1, exp_rb: 16'h0000};
        vecs[1] = '{cfg: 16'h1234, cfg_late: 16'h1234, exp_rb: 16'hDAF1};
        vecs[2] = '{cfg: 16'h8001, cfg_late: 16'h7FFE, exp_rb: 16'h1234};
        vecs[3] = '{cfg: 16'hFFFF, cfg_late: 16'h0000, exp_rb: 16'h8001};

        rstb_sr = 1'b0;
        a_start = 1'b0;
        a_cfg   = '0;
        b_start = 1'b0;
        b_cfg   = '0;
        chain_a = '0;
        chain_b = '0;

        repeat (2) tick();
        check("reset_readback_a", 32'(a_readback), 32'h0);
        rstb_sr = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 4; v++) begin
            run_a(vecs[v].cfg, vecs[v].cfg_late, vecs[v].exp_rb, 1'b0, $sformatf("vec%0d", v));
        end

        // start held high through the whole sequence, including DONE.
        run_a(16'h0F0F, 16'h0F0F, 16'hFFFF, 1'b1, "hold");
        repeat (3) tick();

        // Reset during SHIFT cycle 7: immediate reset values, no strobes afterwards.
        for (int k = 0; k <= 7; k++) q_a.push_back(expect_at(WA, GA, k, 16'hA5C3 >> k));
        a_cfg   = 16'hA5C3;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        shift_a = WA;
        repeat (7) tick();
        #2;
        rstb_sr = 1'b0;
        #1;
        check("abort_outputs", 32'(obs_t'({a_busy, a_done, a_sr_in, a_select, a_load_sc, a_load_scd})),
              32'(IDLE_OBS));
        check("abort_readback", 32'(a_readback), 32'h0);
        q_a.delete();
        shift_a  = 0;
        snapshot = chain_a;
        repeat (3) tick();
        rstb_sr = 1'b1;
        repeat (2) tick();
        run_a(16'h3C5A, 16'h3C5A, snapshot, 1'b0, "post_reset");

        // Single-bit chain with no gaps: SHIFT, LDSC, LDSCD, DONE.
        for (int k = 0; k <= WB + 2*GB + 2; k++) q_b.push_back(expect_at(WB, GB, k, 1'b1));
        b_cfg   = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_cfg   = 1'b0;
        shift_b = WB;
        repeat (WB + 2*GB + 3) tick();
        check("b_readback", 32'(b_readback), 32'h0);
        check("b_chain", 32'(chain_b), 32'h1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
